// File: rtl/digi_pkg.sv
// Shared constants for the digitizer readout path.
//   state_t     : readout_packer FSM encodings
//   SYNC_BYTE   : first byte of every channel header
//   header_byte : selects one of the four header bytes
//   sample_byte : selects the high or low byte of a zero-extended sample
package digi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int unsigned HDR_BYTES = 4;

    // Header order: sync, channel index, count high, count low.
    function automatic logic [7:0] header_byte(input logic [1:0]  idx,
                                               input logic [7:0]  ch,
                                               input logic [15:0] cnt);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = ch;
            2'd2:    b = cnt[15:8];
            default: b = cnt[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [7:0] sample_byte(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with show-ahead read port.
//   clk, reset   : clock, synchronous active-high reset
//   push/wr_data : write one sample (ignored when full)
//   pop          : retire the head sample (ignored when empty)
//   rd_data_c    : head sample, valid while empty is low
//   full, empty  : occupancy flags
//   count        : current occupancy, 0..FDEPTH
module sample_fifo #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned FDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rd_data_c,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(FDEPTH):0]   count
);

    localparam int unsigned AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int unsigned CW = $clog2(FDEPTH) + 1;

    logic [WIDTH-1:0] r_mem [FDEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign rd_data_c = r_mem[r_rd_ptr];
    assign full      = (r_count == CW'(FDEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;

endmodule

// File: rtl/readout_packer.sv
// Reads one event from NCHAN digitizer ring buffers and serialises it as
// bytes: per channel a 4-byte header then 2 bytes per sample.
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle request to read out an event (IDLE only)
//   how_many     : samples per channel, captured on start
//   read_request : one-hot-or-zero per-channel read strobe
//   ch_data      : channel data buses, returned RD_LATENCY cycles after a strobe
//   out_data/out_valid/out_ready : byte stream with valid/ready handshake
//   busy         : event in progress
//   done         : one-cycle pulse after the last byte of the event
module readout_packer
    import digi_pkg::*;
#(
    parameter int unsigned NCHAN      = 4,
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned SIZE       = 12,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FDEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SIZE-1:0]         how_many,
    output logic [NCHAN-1:0]        read_request,
    input  logic [NCHAN*WIDTH-1:0]  ch_data,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned CNT_W = $clog2(FDEPTH) + 1;
    localparam int unsigned CTR_W = SIZE + 1;

    state_t              r_state,        w_state_nxt;
    logic [CH_W-1:0]     r_ch,           w_ch_nxt;
    logic [SIZE-1:0]     r_count,        w_count_nxt;
    logic [CTR_W-1:0]    r_issued,       w_issued_nxt;
    logic [CTR_W-1:0]    r_popped,       w_popped_nxt;
    logic [1:0]          r_hdr_idx,      w_hdr_idx_nxt;
    logic                r_byte_lo,      w_byte_lo_nxt;
    logic [CNT_W-1:0]    r_in_flight,    w_in_flight_nxt;
    logic [NCHAN-1:0]    r_read_request, w_read_request_nxt;
    logic [7:0]          r_out_data,     w_out_data_nxt;
    logic                r_out_valid,    w_out_valid_nxt;
    logic                r_busy,         w_busy_nxt;
    logic                r_done,         w_done_nxt;
    logic [RD_LATENCY-1:0] r_vld;

    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [CNT_W-1:0]    w_credit;
    logic [WIDTH-1:0]    w_push_data;
    logic [WIDTH-1:0]    w_rd_data;
    logic [15:0]         w_sample16;
    logic [15:0]         w_count16;
    logic                w_out_free;

    // Channel index is stable for the whole DATA phase, so returning data
    // is always taken from the current channel's bus.
    assign w_push      = r_vld[RD_LATENCY-1];
    assign w_push_data = ch_data[r_ch*WIDTH +: WIDTH];
    assign w_sample16  = 16'(w_rd_data);
    assign w_count16   = 16'(r_count);
    assign w_out_free  = !r_out_valid || out_ready;
    // Occupied slots plus slots promised to requests still in the pipe.
    assign w_credit    = w_fifo_count + r_in_flight;

    sample_fifo #(
        .WIDTH  (WIDTH),
        .FDEPTH (FDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .wr_data   (w_push_data),
        .pop       (w_pop),
        .rd_data_c (w_rd_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_fifo_count)
    );

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_ch_nxt           = r_ch;
        w_count_nxt        = r_count;
        w_issued_nxt       = r_issued;
        w_popped_nxt       = r_popped;
        w_hdr_idx_nxt      = r_hdr_idx;
        w_byte_lo_nxt      = r_byte_lo;
        w_busy_nxt         = r_busy;
        w_done_nxt         = 1'b0;
        w_read_request_nxt = '0;
        w_out_valid_nxt    = r_out_valid && !out_ready;
        w_out_data_nxt     = r_out_data;
        w_issue            = 1'b0;
        w_pop              = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_count_nxt   = how_many;
                    w_ch_nxt      = '0;
                    w_hdr_idx_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_HEADER;
                end
            end

            ST_HEADER: begin
                if (w_out_free) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = header_byte(r_hdr_idx, 8'(r_ch), w_count16);
                    w_hdr_idx_nxt   = r_hdr_idx + 2'd1;
                    if (r_hdr_idx == 2'(HDR_BYTES - 1)) begin
                        w_issued_nxt  = '0;
                        w_popped_nxt  = '0;
                        w_byte_lo_nxt = 1'b0;
                        w_state_nxt   = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (!w_full && (r_issued < {1'b0, r_count}) &&
                    (w_credit < CNT_W'(FDEPTH))) begin
                    w_issue                  = 1'b1;
                    w_read_request_nxt[r_ch] = 1'b1;
                    w_issued_nxt             = r_issued + CTR_W'(1);
                end
                // Every sample popped implies every request returned; leave
                // once the last byte has left the output register.
                if (r_popped == {1'b0, r_count}) begin
                    if (w_out_free) begin
                        w_state_nxt = ST_NEXT;
                    end
                end else if (w_out_free && !w_empty) begin
                    w_out_valid_nxt = 1'b1;
                    if (!r_byte_lo) begin
                        w_out_data_nxt = sample_byte(w_sample16, 1'b1);
                        w_byte_lo_nxt  = 1'b1;
                    end else begin
                        w_out_data_nxt = sample_byte(w_sample16, 1'b0);
                        w_byte_lo_nxt  = 1'b0;
                        w_pop          = 1'b1;
                        w_popped_nxt   = r_popped + CTR_W'(1);
                    end
                end
            end

            ST_NEXT: begin
                if (r_ch == CH_W'(NCHAN - 1)) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_ch_nxt      = r_ch + CH_W'(1);
                    w_hdr_idx_nxt = '0;
                    w_state_nxt   = ST_HEADER;
                end
            end

            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_in_flight_nxt = r_in_flight + CNT_W'(w_issue) - CNT_W'(w_push);
    end

    // State and output registers; reset also flushes the return pipe so
    // data from pre-reset requests is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_ch           <= '0;
            r_count        <= '0;
            r_issued       <= '0;
            r_popped       <= '0;
            r_hdr_idx      <= '0;
            r_byte_lo      <= 1'b0;
            r_in_flight    <= '0;
            r_read_request <= '0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_vld          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_ch           <= w_ch_nxt;
            r_count        <= w_count_nxt;
            r_issued       <= w_issued_nxt;
            r_popped       <= w_popped_nxt;
            r_hdr_idx      <= w_hdr_idx_nxt;
            r_byte_lo      <= w_byte_lo_nxt;
            r_in_flight    <= w_in_flight_nxt;
            r_read_request <= w_read_request_nxt;
            r_out_data     <= w_out_data_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_vld[0]       <= |r_read_request;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    assign read_request = r_read_request;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_readout_packer.sv
// Directed bench for readout_packer with a ring-buffer return model.
module tb_readout_packer;

    localparam int unsigned NCHAN  = 4;
    localparam int unsigned WIDTH  = 12;
    localparam int unsigned SIZE   = 12;
    localparam int unsigned RDL    = 2;
    localparam int unsigned FDEPTH = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [SIZE-1:0]        how_many;
    logic [NCHAN-1:0]       read_request;
    logic [NCHAN*WIDTH-1:0] ch_data;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    readout_packer #(
        .NCHAN      (NCHAN),
        .WIDTH      (WIDTH),
        .SIZE       (SIZE),
        .RD_LATENCY (RDL),
        .FDEPTH     (FDEPTH)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .how_many     (how_many),
        .read_request (read_request),
        .ch_data      (ch_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    // Channel model: the n-th read of channel i in an event returns 0x100*i+n,
    // RDL cycles after the strobe; idle buses carry a junk pattern.
    typedef struct packed {
        logic             v;
        logic [1:0]       ch;
        logic [WIDTH-1:0] d;
    } ret_t;

    ret_t       pipe [RDL];
    logic [7:0] rcnt [NCHAN];

    always @(posedge clk) begin : chan_model
        int idx;
        idx = 0;
        for (int i = 0; i < NCHAN; i++) if (read_request[i]) idx = i;
        for (int k = RDL - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0].v  <= |read_request;
        pipe[0].ch <= 2'(idx);
        pipe[0].d  <= WIDTH'(32'h100 * idx + int'(rcnt[idx]));
        if (reset || (start && !busy)) begin
            for (int i = 0; i < NCHAN; i++) rcnt[i] <= 8'd0;
        end else if (|read_request) begin
            rcnt[idx] <= rcnt[idx] + 8'd1;
        end
    end

    always_comb begin
        ch_data = {NCHAN{12'hEEE}};
        if (pipe[RDL-1].v === 1'b1)
            ch_data[int'(pipe[RDL-1].ch)*WIDTH +: WIDTH] = pipe[RDL-1].d;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] got [8192];
    int         n_got = 0;
    int         done_cnt = 0;
    int         rr_cycles = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_b [1024];
    int         exp_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
        end
        chk("onehot0", 32'($onehot0(read_request)), 1);
        chk("fifo_bound", 32'(u_dut.w_fifo_count <= FDEPTH), 1);
        chk("no_overflow", 32'(u_dut.w_push && u_dut.w_full), 0);
        if (read_request != '0) rr_cycles++;
        if (done === 1'b1) done_cnt++;
        if (out_valid && out_ready && !reset && n_got < 8192) begin
            got[n_got] = out_data;
            n_got++;
        end
        prev_stall = out_valid && !out_ready && !reset;
        prev_data  = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input int hm);
        logic [15:0] v;
        logic [15:0] c16;
        exp_n = 0;
        c16 = 16'(hm);
        for (int c = 0; c < NCHAN; c++) begin
            exp_b[exp_n] = 8'hA5;      exp_n++;
            exp_b[exp_n] = 8'(c);      exp_n++;
            exp_b[exp_n] = c16[15:8];  exp_n++;
            exp_b[exp_n] = c16[7:0];   exp_n++;
            for (int n = 0; n < hm; n++) begin
                v = 16'(32'h100 * c + n);
                exp_b[exp_n] = v[15:8]; exp_n++;
                exp_b[exp_n] = v[7:0];  exp_n++;
            end
        end
    endtask

    task automatic compare_stream(input string tag, input int base);
        chk({tag, "_len"}, 32'(n_got - base), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (base + i < n_got)
                chk($sformatf("%s_byte%0d", tag, i), 32'(got[base+i]), 32'(exp_b[i]));
        end
    endtask

    task automatic run_event(input int hm, input bit rnd, input bit mid_start,
                             input bit fin_start, output int base);
        int d0;
        int cyc;
        bit fin_seen;
        base = n_got;
        d0 = done_cnt;
        how_many = SIZE'(hm);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        cyc = 0;
        fin_seen = 0;
        while (cyc < 6000 && !fin_seen) begin
            out_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            start = mid_start && (cyc == 15);
            if (done) begin
                start = fin_start;
                fin_seen = 1;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("event_finished", 32'(fin_seen), 1);
        chk("done_pulses", 32'(done_cnt - d0), 1);
        chk("done_low_after", 32'(done), 0);
        chk("busy_low_after", 32'(busy), 0);
    endtask

    initial begin
        int base;
        int rr0;
        int cyc;
        int n0;

        reset = 1'b1;
        start = 1'b0;
        how_many = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_read_request", 32'(read_request), 0);

        // 4 channels x 3 samples, full throughput.
        run_event(3, 1'b0, 1'b0, 1'b0, base);
        build_exp(3);
        chk("ev3_total", 32'(exp_n), 40);
        compare_stream("ev3", base);

        // Header-only event.
        rr0 = rr_cycles;
        run_event(0, 1'b0, 1'b0, 1'b0, base);
        build_exp(0);
        compare_stream("ev0", base);
        chk("ev0_no_requests", 32'(rr_cycles - rr0), 0);

        // Back-pressure at ~30% ready duty.
        run_event(20, 1'b1, 1'b0, 1'b0, base);
        build_exp(20);
        compare_stream("ev20", base);

        // Stray starts mid-event and in the FINISH cycle.
        run_event(2, 1'b0, 1'b1, 1'b1, base);
        build_exp(2);
        compare_stream("ev2", base);
        n0 = n_got;
        rr0 = rr_cycles;
        repeat (20) tick();
        chk("no_second_event_bytes", 32'(n_got - n0), 0);
        chk("no_second_event_reqs", 32'(rr_cycles - rr0), 0);
        chk("no_second_event_busy", 32'(busy), 0);

        // Reset during DATA of channel 2, then a clean event.
        base = n_got;
        how_many = SIZE'(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while ((n_got - base) < 98 && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("reached_ch2_data", 32'((n_got - base) >= 98), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_read_request", 32'(read_request), 0);
        chk("mid_rst_fifo_count", 32'(u_dut.w_fifo_count), 0);
        reset = 1'b0;
        n0 = n_got;
        repeat (5) tick();
        chk("post_rst_quiet", 32'(n_got - n0), 0);
        run_event(1, 1'b0, 1'b0, 1'b0, base);
        build_exp(1);
        compare_stream("ev_after_rst", base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/readout_packer.md
READOUT_PACKER -- requirements
Module: readout_packer

Interface
REQ-001 Parameter NCHAN, default 4: number of digitizer channels read out per event.
REQ-002 Parameter WIDTH, default 12: sample width; the block supports WIDTH values from 9 to 16.
REQ-003 Parameter SIZE, default 12: sample-count width, matching the channel ring-buffer address width.
REQ-004 Parameter RD_LATENCY, default 2: cycles from a high read_request bit to the matching valid ch_data word.
REQ-005 Parameter FDEPTH, default 8 (power of 2): depth of the internal sample FIFO.
REQ-006 Port clk, input, 1 bit: the block's single clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port start, input, 1 bit: one-cycle pulse requesting readout of one event.
REQ-009 Port how_many, input, SIZE bits: samples per channel; captured when start is accepted.
REQ-010 Port read_request, output, NCHAN bits: per-channel read strobe; at most one bit is high in any cycle.
REQ-011 Port ch_data, input, NCHAN*WIDTH bits: concatenated channel data_out buses; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 Port out_data, output, 8 bits: byte stream.
REQ-013 Port out_valid, output, 1 bit: out_data is valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the byte; a transfer occurs when out_valid and out_ready are both high.
REQ-015 Port busy, output, 1 bit: high from start acceptance until done.
REQ-016 Port done, output, 1 bit: one-cycle pulse after the last byte of the event transfers.

Function
REQ-017 The state machine has exactly five states: IDLE, HEADER, DATA, NEXT and FINISH.
REQ-018 IDLE: start accepted only in IDLE; on acceptance, latch how_many, set channel index to 0, go to HEADER next cycle; start outside IDLE is ignored.
REQ-019 HEADER: emit 4 bytes in order -- 0xA5, channel index (8 bits), count[15:8], count[7:0] -- where count is how_many zero-extended to 16 bits; then go to DATA.
REQ-020 DATA: each sample is emitted as 2 bytes, high byte first; the 16-bit value is the sample zero-extended, giving {zeros, sample[WIDTH-1:8]} followed by sample[7:0].
REQ-021 Request issue: assert read_request[ch] for one cycle per sample while issued < how_many and (fifo_count + in_flight) < FDEPTH; in_flight counts requests not yet returned.
REQ-022 Each read_request pulse returns ch_data[ch] exactly RD_LATENCY cycles later; the packer captures it into the FIFO then, using a RD_LATENCY-deep valid shift register.
REQ-023 Credit rule: the FIFO never overflows under any out_ready pattern; captured samples are never dropped.
REQ-024 DATA exits to NEXT once all how_many samples have been issued, returned and fully transferred (both bytes).
REQ-025 how_many = 0: the header is emitted with count 0, no read_request is asserted, and DATA exits immediately.
REQ-026 NEXT: if index = NCHAN-1, go to FINISH; otherwise increment index and go to HEADER. NEXT lasts one cycle.
REQ-027 FINISH: pulse done for one cycle, clear busy, return to IDLE; a start arriving in this same cycle is ignored.
REQ-028 Output hold: while out_valid is high and out_ready is low, out_data is held stable and out_valid stays high.
REQ-029 out_valid may be high in back-to-back cycles; full throughput is 1 byte per cycle.
REQ-030 Sample counters are SIZE+1 bits wide, so how_many = 2^SIZE-1 never wraps.

Reset
REQ-031 Reset values: state IDLE, read_request = 0, out_valid = 0, out_data = 0, busy = 0, done = 0; FIFO, counters and valid pipeline cleared.
REQ-032 Reset asserted mid-event aborts the event; data returning after reset release from pre-reset requests is discarded.

Structure
REQ-033 State encodings and the header sync byte 0xA5 are defined as constants in a shared package, digi_pkg.
REQ-034 The sample FIFO is a separate sub-module, sample_fifo, parameterized by WIDTH and FDEPTH, with push, pop, full, empty and count signals.

Verification
REQ-035 NCHAN=4, how_many=3, out_ready=1, channel i returns 0x100*i + n: stream is 4×(A5, i, 00, 03, then 3 sample byte pairs) = 40 bytes, then done pulses once.
REQ-036 how_many=0: 16 header-only bytes are emitted, read_request stays 0 throughout, and done pulses.
REQ-037 out_ready random at 30% duty, how_many=20: byte sequence matches the REQ-035 model, the FIFO never reaches more than FDEPTH entries, and out_data is stable during every stall.
REQ-038 start pulsed again mid-event and in the FINISH cycle: no second event and no extra header bytes appear.
REQ-039 Reset asserted during DATA of channel 2: all outputs reach their reset values next cycle; a new start yields a clean event beginning with A5, 00.
REQ-040 Across all scenarios: at most one read_request bit is high per cycle (onehot0 check).
